serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial unsigned subtractor computing `difference = a - b` over WIDTH-bit operands, one bit per clock, LSB first. It uses a single registered borrow. The per-bit datapath is two cascaded half-subtractor stages (operand bits, then borrow-in) feeding a borrow flip-flop. It sits directly downstream of the combinational half-subtractor cell and consumes its difference/borrow terms. It is the multi-bit arithmetic stage for area-constrained paths where a ripple array is too large.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  reset, synchronous, active-high; sampled on the rising edge of clk.
- start  input  1  request; accepted only in IDLE.
- a  input  WIDTH  minuend; sampled on the accepting edge only.
- b  input  WIDTH  subtrahend; sampled on the accepting edge only.
- difference  output  WIDTH  registered result, `(a - b) mod 2^WIDTH`; holds the last completed result.
- borrow  output  1  registered final borrow-out; 1 iff a < b (unsigned); holds with difference.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse marking difference/borrow newly valid.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1:
  - latch a and b into shift registers sa and sb;
  - clear the borrow flop bf;
  - clear bit counter cnt;
  - go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN, each edge, on bits sa[0], sb[0]:
  - stage 1: `d1 = sa[0]^sb[0]`, `b1 = ~sa[0] & sb[0]`;
  - stage 2: `d = d1^bf`, `b2 = ~d1 & bf`;
  - `bf <= b1 | b2`;
  - shift d into the MSB of internal result register sr; shift sa and sb right by one;
  - `cnt <= cnt + 1`.
- RUN, edge that processes bit WIDTH-1:
  - copy the final sr (including this bit) to difference;
  - copy the final borrow (b1|b2 of this bit) to borrow;
  - go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- start in RUN or DONE is ignored; it is not queued. start held high re-triggers on the first IDLE cycle.
- difference and borrow are never altered during RUN. They change only on the completing edge.
- cnt width is `$clog2(WIDTH+1)`; no wrap-around occurs within an operation.
- Reset, at any time including mid-RUN:
  - state=IDLE;
  - difference=0, borrow=0, busy=0, done=0;
  - bf, cnt, sa, sb, sr cleared;
  - the in-flight operation is discarded and produces no done.

## Timing
- Accepting edge E0 (IDLE, start=1): busy=1 from after E0.
- Bits processed on edges E1..E(WIDTH).
- After E(WIDTH): difference/borrow valid, done=1, busy=1.
- After E(WIDTH+1): done=0, busy=0, state IDLE.
- Latency from start edge to done high: WIDTH cycles.
- Throughput: one operation per WIDTH+2 cycles when start is held high.
- Reset values: difference=0, borrow=0, busy=0, done=0.
- No combinational path from inputs to outputs.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, start pulse -> difference=0x1E, borrow=0; done high exactly 8 cycles after the start edge, for 1 cycle.
- WIDTH=8, a=0x00, b=0x01 -> difference=0xFF, borrow=1. Then a=0xA5, b=0xA5 -> difference=0x00, borrow=0, and the previous result holds until completion.
- WIDTH=8, start held high for 30 cycles with a=0x80, b=0x7F -> done pulses every 10 cycles with difference=0x01, borrow=0. Changing a/b mid-RUN does not affect the result.
- WIDTH=8, assert rst at cycle 4 of RUN for a=0x10, b=0x20 -> all outputs 0 next edge, no done pulse. Then a fresh start with a=0x20, b=0x10 -> difference=0x10, borrow=0.
- WIDTH=1, all four (a,b) pairs -> (0,0):0/0, (0,1):1/1, (1,0):1/0, (1,1):0/0 as difference/borrow; done 1 cycle after start.
- WIDTH=16, 1000 random pairs vs reference model `(a-b) mod 65536` with `borrow = (a<b)` -> zero mismatches; busy never low between start and done.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: difference = a - b, one bit per clock, LSB first.
// Two cascaded half-subtractor stages feed a single registered borrow.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] difference,
  output logic             borrow,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sa_q, sb_q, sr_q, diff_q;
  logic [CW-1:0]    cnt_q;
  logic             bf_q, borrow_q, busy_q, done_q;

  logic             d1, b1, d, b2, borrow_d;
  logic [WIDTH-1:0] sr_d;

  // Stage 1 subtracts the operand bits, stage 2 subtracts the stored borrow.
  always_comb begin
    d1       = sa_q[0] ^ sb_q[0];
    b1       = ~sa_q[0] & sb_q[0];
    d        = d1 ^ bf_q;
    b2       = ~d1 & bf_q;
    borrow_d = b1 | b2;
    // Shift expression rather than a part-select so WIDTH=1 stays legal.
    sr_d     = (sr_q >> 1) | (WIDTH'(d) << (WIDTH - 1));
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; the shift registers are cleared on reset as well since
  // they are a handful of flops, not a memory array.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      sr_q     <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      bf_q     <= 1'b0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            sa_q    <= a;
            sb_q    <= b;
            bf_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          bf_q  <= borrow_d;
          sr_q  <= sr_d;
          sa_q  <= sa_q >> 1;
          sb_q  <= sb_q >> 1;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST_BIT) begin
            diff_q   <= sr_d;
            borrow_q <= borrow_d;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign difference = diff_q;
  assign borrow     = borrow_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor at WIDTH 1, 8 and 16: directed steps plus a random
// run, with expected results queued at start and compared when done pulses.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        start1, busy1, done1, bw1;
  logic [0:0]  a1, b1, dif1;
  logic        start8, busy8, done8, bw8;
  logic [7:0]  a8, b8, dif8;
  logic        start16, busy16, done16, bw16;
  logic [15:0] a16, b16, dif16;

  serial_subtractor #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .difference(dif1), .borrow(bw1), .busy(busy1), .done(done1));
  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .difference(dif8), .borrow(bw8), .busy(busy8), .done(done8));
  serial_subtractor #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
    .difference(dif16), .borrow(bw16), .busy(busy16), .done(done16));

  typedef struct packed {
    logic [15:0] d;
    logic        bw;
  } exp_t;

  exp_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int w, input logic st, input logic [15:0] av, input logic [15:0] bv);
    case (w)
      1:       begin start1  = st; a1  = av[0:0]; b1  = bv[0:0]; end
      8:       begin start8  = st; a8  = av[7:0]; b8  = bv[7:0]; end
      default: begin start16 = st; a16 = av;      b16 = bv;      end
    endcase
  endtask

  function automatic logic f_done(input int w);
    case (w)
      1:       return done1;
      8:       return done8;
      default: return done16;
    endcase
  endfunction

  function automatic logic f_busy(input int w);
    case (w)
      1:       return busy1;
      8:       return busy8;
      default: return busy16;
    endcase
  endfunction

  function automatic logic [15:0] f_diff(input int w);
    case (w)
      1:       return {15'd0, dif1};
      8:       return {8'd0, dif8};
      default: return dif16;
    endcase
  endfunction

  function automatic logic f_bw(input int w);
    case (w)
      1:       return bw1;
      8:       return bw8;
      default: return bw16;
    endcase
  endfunction

  // One complete operation on the instance of width w, starting from IDLE.
  task automatic do_op(input int w, input logic [15:0] av_in, input logic [15:0] bv_in);
    logic [15:0] mask, av, bv, prev_d;
    logic        prev_bw, busy_ok, hold_ok;
    exp_t        e;
    int          lat;
    mask    = 16'((32'd1 << w) - 1);
    av      = av_in & mask;
    bv      = bv_in & mask;
    prev_d  = f_diff(w);
    prev_bw = f_bw(w);
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    e.d  = (av - bv) & mask;
    e.bw = (av < bv);
    sb_q.push_back(e);
    drive(w, 1'b1, av, bv);
    tick();
    drive(w, 1'b0, 16'hFFFF, 16'h0000);
    check("busy_after_accept", 32'(f_busy(w)), 32'd1);
    lat = 0;
    while (lat < 60) begin
      tick();
      lat++;
      if (f_done(w)) break;
      if (!f_busy(w)) busy_ok = 1'b0;
      if (f_diff(w) !== prev_d || f_bw(w) !== prev_bw) hold_ok = 1'b0;
    end
    check("done_latency", 32'(lat), 32'(w));
    check("busy_in_run", 32'(busy_ok), 32'd1);
    check("result_held_in_run", 32'(hold_ok), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("difference", 32'(f_diff(w)), 32'(e.d));
      check("borrow", 32'(f_bw(w)), 32'(e.bw));
    end
    check("busy_with_done", 32'(f_busy(w)), 32'd1);
    tick();
    check("done_one_cycle", 32'(f_done(w)), 32'd0);
    check("busy_back_low", 32'(f_busy(w)), 32'd0);
  endtask

  initial begin
    int pulses;
    rst = 1'b1;
    drive(1, 1'b0, 16'h0, 16'h0);
    drive(8, 1'b0, 16'h0, 16'h0);
    drive(16, 1'b0, 16'h0, 16'h0);
    tick();
    tick();
    check("rst_diff8", 32'(dif8), 32'd0);
    check("rst_bw8", 32'(bw8), 32'd0);
    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_done8", 32'(done8), 32'd0);
    check("rst_diff16", 32'(dif16), 32'd0);
    check("rst_busy1", 32'(busy1), 32'd0);
    rst = 1'b0;
    tick();

    // Directed 8-bit cases.
    do_op(8, 16'h5A, 16'h3C);
    do_op(8, 16'h00, 16'h01);
    do_op(8, 16'hA5, 16'hA5);

    // Start held high: a new operation every WIDTH+2 cycles, mid-RUN a/b changes ignored.
    pulses = 0;
    drive(8, 1'b1, 16'h80, 16'h7F);
    tick();
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 3)  drive(8, 1'b1, 16'hFF, 16'h00);
      if (k == 7)  drive(8, 1'b1, 16'h80, 16'h7F);
      if (k == 29) drive(8, 1'b0, 16'h80, 16'h7F);
      if (done8) begin
        pulses++;
        check("held_done_phase", 32'(k % 10), 32'd8);
        check("held_difference", 32'(dif8), 32'h01);
        check("held_borrow", 32'(bw8), 32'd0);
      end
    end
    check("held_pulse_count", 32'(pulses), 32'd3);

    // Reset during RUN discards the operation.
    sb_q.push_back('{d: 16'hF0, bw: 1'b1});
    drive(8, 1'b1, 16'h10, 16'h20);
    tick();
    drive(8, 1'b0, 16'h10, 16'h20);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_diff", 32'(dif8), 32'd0);
    check("midrst_bw", 32'(bw8), 32'd0);
    check("midrst_busy", 32'(busy8), 32'd0);
    check("midrst_done", 32'(done8), 32'd0);
    sb_q.delete();
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done8) pulses++;
    end
    check("midrst_no_done", 32'(pulses), 32'd0);
    do_op(8, 16'h20, 16'h10);

    // WIDTH=1, all operand pairs.
    for (int i = 0; i < 4; i++) do_op(1, 16'(i >> 1), 16'(i & 1));

    // WIDTH=16 corners and random pairs.
    do_op(16, 16'h0000, 16'hFFFF);
    do_op(16, 16'hFFFF, 16'h0000);
    for (int i = 0; i < 1000; i++)
      do_op(16, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
